// File: rtl/wbup_sfifo.sv
// rtl/wbup_sfifo.sv - synchronous first-word-fall-through FIFO holding outstanding sub-word indices.
module wbup_sfifo #(
  parameter int BW     = 1,
  parameter int LGFLEN = 5
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr,
  input  logic [BW-1:0] i_data,
  output logic          o_full,
  input  logic          i_rd,
  output logic [BW-1:0] o_data,
  output logic          o_empty
);
  localparam logic [LGFLEN:0]   DEPTH    = {1'b1, {LGFLEN{1'b0}}};
  localparam logic [LGFLEN:0]   FILL_ONE = {{LGFLEN{1'b0}}, 1'b1};
  localparam logic [LGFLEN-1:0] PTR_ONE  = {{(LGFLEN-1){1'b0}}, 1'b1};

  logic [BW-1:0]     mem_q [0:(1<<LGFLEN)-1];
  logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LGFLEN:0]   fill_q, fill_d;
  logic              do_wr, do_rd;

  assign o_full  = (fill_q == DEPTH);
  assign o_empty = (fill_q == '0);
  assign o_data  = mem_q[rd_ptr_q];

  always_comb begin
    do_wr    = i_wr && !o_full;
    do_rd    = i_rd && !o_empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_wr, do_rd})
      2'b10:   fill_d = fill_q + FILL_ONE;
      2'b01:   fill_d = fill_q - FILL_ONE;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end
endmodule

// File: rtl/wbup.sv
// rtl/wbup.sv - Wishbone upsizer: one narrow pipelined beat becomes one wide beat, reads narrowed back.
module wbup #(
  parameter int   ADDRESS_WIDTH     = 28,
  parameter int   SMALL_DW          = 32,
  parameter int   WIDE_DW           = 64,
  parameter logic OPT_LITTLE_ENDIAN = 1'b0,
  parameter int   LGFIFO            = 5,
  parameter logic OPT_LOWPOWER      = 1'b0
) (
  input  logic                                         i_clk,
  input  logic                                         i_reset,
  input  logic                                         i_scyc,
  input  logic                                         i_sstb,
  input  logic                                         i_swe,
  input  logic [ADDRESS_WIDTH-$clog2(SMALL_DW/8)-1:0]  i_saddr,
  input  logic [SMALL_DW-1:0]                          i_sdata,
  input  logic [SMALL_DW/8-1:0]                        i_ssel,
  output logic                                         o_sstall,
  output logic                                         o_sack,
  output logic [SMALL_DW-1:0]                          o_sdata,
  output logic                                         o_serr,
  output logic                                         o_wcyc,
  output logic                                         o_wstb,
  output logic                                         o_wwe,
  output logic [ADDRESS_WIDTH-$clog2(WIDE_DW/8)-1:0]   o_waddr,
  output logic [WIDE_DW-1:0]                           o_wdata,
  output logic [WIDE_DW/8-1:0]                         o_wsel,
  input  logic                                         i_wstall,
  input  logic                                         i_wack,
  input  logic [WIDE_DW-1:0]                           i_wdata,
  input  logic                                         i_werr
);
  localparam int SSEL = SMALL_DW/8;
  localparam int WSEL = WIDE_DW/8;
  localparam int WAW  = ADDRESS_WIDTH - $clog2(WIDE_DW/8);

  generate
    if (WIDE_DW == SMALL_DW) begin : g_pass
      assign o_wcyc   = i_scyc;
      assign o_wstb   = i_sstb;
      assign o_wwe    = i_swe;
      assign o_waddr  = i_saddr;
      assign o_wdata  = i_sdata;
      assign o_wsel   = i_ssel;
      assign o_sstall = i_wstall;
      assign o_sack   = i_wack;
      assign o_sdata  = i_wdata;
      assign o_serr   = i_werr;
      logic unused_pass;
      assign unused_pass = &{1'b0, i_clk, i_reset};
    end else begin : g_up
      localparam int R   = WIDE_DW/SMALL_DW;
      localparam int L   = $clog2(R);
      localparam int SAW = ADDRESS_WIDTH - $clog2(SMALL_DW/8);

      logic                wcyc_q, wcyc_d, wstb_q, wstb_d, wwe_q, wwe_d;
      logic [WAW-1:0]      waddr_q, waddr_d;
      logic [WIDE_DW-1:0]  wdata_q, wdata_d;
      logic [WSEL-1:0]     wsel_q, wsel_d;
      logic                sack_q, sack_d, serr_q, serr_d;
      logic [SMALL_DW-1:0] sdata_q, sdata_d;
      logic                stall, accept, pop, werr_hit, fifo_reset, fifo_full, fifo_empty;
      logic [L-1:0]        idx, push_lane, pop_idx, pop_lane;

      wbup_sfifo #(.BW(L), .LGFLEN(LGFIFO)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (fifo_reset),
        .i_wr    (accept),
        .i_data  (idx),
        .o_full  (fifo_full),
        .i_rd    (pop),
        .o_data  (pop_idx),
        .o_empty (fifo_empty)
      );

      always_comb begin
        stall      = (wstb_q && i_wstall) || fifo_full || serr_q;
        accept     = i_scyc && i_sstb && !stall;
        werr_hit   = wcyc_q && i_werr;
        pop        = i_wack && wcyc_q && i_scyc;
        fifo_reset = i_reset || !i_scyc || werr_hit;
        idx        = i_saddr[L-1:0];
        // Lanes count from the LSB; big-endian puts sub-word 0 in the top lane.
        push_lane  = OPT_LITTLE_ENDIAN ? idx : ~idx;
        pop_lane   = OPT_LITTLE_ENDIAN ? pop_idx : ~pop_idx;

        wcyc_d = wcyc_q;
        if (i_scyc && i_sstb) wcyc_d = 1'b1;
        if (!i_scyc || werr_hit || serr_q) wcyc_d = 1'b0;

        wstb_d = wstb_q;
        if (!i_wstall) wstb_d = 1'b0;
        if (accept) wstb_d = 1'b1;
        if (!i_scyc || werr_hit) wstb_d = 1'b0;

        wwe_d   = wwe_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wsel_d  = wsel_q;
        if (accept) begin
          wwe_d   = i_swe;
          waddr_d = i_saddr[SAW-1:L];
          wdata_d = {R{i_sdata}};
          wsel_d  = '0;
          wsel_d[int'(push_lane)*SSEL +: SSEL] = i_ssel;
        end else if (OPT_LOWPOWER && !wstb_q) begin
          waddr_d = '0;
          wdata_d = '0;
          wsel_d  = '0;
        end

        sack_d  = pop && !i_werr && !fifo_empty;
        serr_d  = werr_hit;
        sdata_d = sdata_q;
        if (sack_d) sdata_d = i_wdata[int'(pop_lane)*SMALL_DW +: SMALL_DW];
        else if (OPT_LOWPOWER) sdata_d = '0;
      end

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          wcyc_q  <= 1'b0;
          wstb_q  <= 1'b0;
          wwe_q   <= 1'b0;
          waddr_q <= '0;
          wdata_q <= '0;
          wsel_q  <= '0;
          sack_q  <= 1'b0;
          serr_q  <= 1'b0;
          sdata_q <= '0;
        end else begin
          wcyc_q  <= wcyc_d;
          wstb_q  <= wstb_d;
          wwe_q   <= wwe_d;
          waddr_q <= waddr_d;
          wdata_q <= wdata_d;
          wsel_q  <= wsel_d;
          sack_q  <= sack_d;
          serr_q  <= serr_d;
          sdata_q <= sdata_d;
        end
      end

      assign o_sstall = stall;
      assign o_wcyc   = wcyc_q;
      assign o_wstb   = wstb_q;
      assign o_wwe    = wwe_q;
      assign o_waddr  = waddr_q;
      assign o_wdata  = wdata_q;
      assign o_wsel   = wsel_q;
      assign o_sack   = sack_q;
      assign o_serr   = serr_q;
      assign o_sdata  = sdata_q;
    end
  endgenerate
endmodule

// File: tb/tb_wbup.sv
// tb/tb_wbup.sv - directed bench for wbup, big- and little-endian instances on shared stimulus.
module tb_wbup;
  logic        clk = 1'b0;
  logic        rst, scyc, sstb, swe, wstall, wack, werr;
  logic [25:0] saddr;
  logic [31:0] sdata;
  logic [3:0]  ssel;
  logic [63:0] wdata_in;

  logic        b_sstall, b_sack, b_serr, b_wcyc, b_wstb, b_wwe;
  logic [31:0] b_sdata;
  logic [24:0] b_waddr;
  logic [63:0] b_wdata;
  logic [7:0]  b_wsel;
  logic        l_sstall, l_sack, l_serr, l_wcyc, l_wstb, l_wwe;
  logic [31:0] l_sdata;
  logic [24:0] l_waddr;
  logic [63:0] l_wdata;
  logic [7:0]  l_wsel;

  int total = 0;
  int bad   = 0;
  int accepted, sacks;

  always #5 clk = ~clk;

  wbup #(.OPT_LITTLE_ENDIAN(1'b0)) u_be (
    .i_clk(clk), .i_reset(rst), .i_scyc(scyc), .i_sstb(sstb), .i_swe(swe),
    .i_saddr(saddr), .i_sdata(sdata), .i_ssel(ssel), .o_sstall(b_sstall),
    .o_sack(b_sack), .o_sdata(b_sdata), .o_serr(b_serr), .o_wcyc(b_wcyc),
    .o_wstb(b_wstb), .o_wwe(b_wwe), .o_waddr(b_waddr), .o_wdata(b_wdata),
    .o_wsel(b_wsel), .i_wstall(wstall), .i_wack(wack), .i_wdata(wdata_in),
    .i_werr(werr)
  );

  wbup #(.OPT_LITTLE_ENDIAN(1'b1)) u_le (
    .i_clk(clk), .i_reset(rst), .i_scyc(scyc), .i_sstb(sstb), .i_swe(swe),
    .i_saddr(saddr), .i_sdata(sdata), .i_ssel(ssel), .o_sstall(l_sstall),
    .o_sack(l_sack), .o_sdata(l_sdata), .o_serr(l_serr), .o_wcyc(l_wcyc),
    .o_wstb(l_wstb), .o_wwe(l_wwe), .o_waddr(l_waddr), .o_wdata(l_wdata),
    .o_wsel(l_wsel), .i_wstall(wstall), .i_wack(wack), .i_wdata(wdata_in),
    .i_werr(werr)
  );

  logic unused_le;
  assign unused_le = &{1'b0, l_sstall, l_serr, l_wcyc, l_wstb, l_wwe, l_waddr, l_wdata};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; scyc = 1'b0; sstb = 1'b0; swe = 1'b0; wstall = 1'b0;
    wack = 1'b0; werr = 1'b0; saddr = '0; sdata = '0; ssel = '0; wdata_in = '0;
    tick(); tick();
    check("rst_wcyc", b_wcyc, 0);
    check("rst_wstb", b_wstb, 0);
    check("rst_wdata", b_wdata, 0);
    check("rst_wsel", b_wsel, 0);
    check("rst_waddr", b_waddr, 0);
    check("rst_sack", b_sack, 0);
    check("rst_sdata", b_sdata, 0);
    check("rst_serr", b_serr, 0);
    check("rst_sstall", b_sstall, 0);
    rst = 1'b0;

    // single write
    scyc = 1'b1; sstb = 1'b1; swe = 1'b1; saddr = 26'd5; sdata = 32'hDEADBEEF; ssel = 4'hF;
    tick();
    sstb = 1'b0;
    check("wr_wstb", b_wstb, 1);
    check("wr_wcyc", b_wcyc, 1);
    check("wr_wwe", b_wwe, 1);
    check("wr_waddr", b_waddr, 2);
    check("wr_wdata", b_wdata, 64'hDEADBEEF_DEADBEEF);
    check("wr_wsel_be", b_wsel, 8'h0F);
    check("wr_wsel_le", l_wsel, 8'hF0);
    wack = 1'b1;
    tick();
    check("wr_wstb_clr", b_wstb, 0);
    check("wr_sack", b_sack, 1);
    wack = 1'b0;
    tick();
    check("wr_sack_clr", b_sack, 0);

    // three back-to-back reads
    swe = 1'b0; sstb = 1'b1; saddr = 26'd4;
    tick();
    saddr = 26'd5;
    tick();
    saddr = 26'd6;
    tick();
    sstb = 1'b0;
    check("rd_waddr", b_waddr, 3);
    check("rd_wstb", b_wstb, 1);
    wack = 1'b1; wdata_in = 64'h11223344_55667788;
    tick();
    check("rd0_sack", b_sack, 1);
    check("rd0_be", b_sdata, 32'h11223344);
    check("rd0_le", l_sdata, 32'h55667788);
    tick();
    check("rd1_sack", b_sack, 1);
    check("rd1_be", b_sdata, 32'h55667788);
    check("rd1_le", l_sdata, 32'h11223344);
    wdata_in = 64'hAAAABBBB_CCCCDDDD;
    tick();
    check("rd2_sack_le", l_sack, 1);
    check("rd2_be", b_sdata, 32'hAAAABBBB);
    check("rd2_le", l_sdata, 32'hCCCCDDDD);
    wack = 1'b0;
    tick();
    check("rd_sack_clr", b_sack, 0);

    // fill the index FIFO with no acks
    accepted = 0; sacks = 0;
    sstb = 1'b1; saddr = 26'd0;
    for (int i = 0; i < 40; i++) begin
      if (!b_sstall) accepted++;
      tick();
      if (b_sack) sacks++;
    end
    sstb = 1'b0;
    check("full_accepted", accepted, 32);
    check("full_sstall", b_sstall, 1);
    check("full_no_sack", sacks, 0);
    scyc = 1'b0;
    tick();
    check("abort_wcyc", b_wcyc, 0);
    check("abort_sstall", b_sstall, 0);

    // wide stall holds off the next request
    scyc = 1'b1; sstb = 1'b1; wstall = 1'b1;
    tick();
    check("wstall_sstall", b_sstall, 1);
    sstb = 1'b0; scyc = 1'b0; wstall = 1'b0;
    tick();

    // bus error on the second return
    scyc = 1'b1; sstb = 1'b1; saddr = 26'd4;
    tick();
    saddr = 26'd5;
    tick();
    saddr = 26'd6;
    tick();
    sstb = 1'b0;
    wack = 1'b1; wdata_in = 64'h11223344_55667788;
    tick();
    check("err_beat1_sack", b_sack, 1);
    check("err_beat1_data", b_sdata, 32'h11223344);
    wack = 1'b0; werr = 1'b1;
    tick();
    check("err_serr", b_serr, 1);
    check("err_no_sack", b_sack, 0);
    check("err_wcyc", b_wcyc, 0);
    check("err_wstb", b_wstb, 0);
    werr = 1'b0; wack = 1'b1;
    tick();
    check("err_serr_once", b_serr, 0);
    check("err_late_ack", b_sack, 0);
    wack = 1'b0;
    sstb = 1'b1; saddr = 26'd7;
    tick();
    sstb = 1'b0;
    wack = 1'b1; wdata_in = 64'h01234567_89ABCDEF;
    tick();
    check("err_after_sack", b_sack, 1);
    check("err_after_be", b_sdata, 32'h89ABCDEF);
    check("err_after_le", l_sdata, 32'h01234567);
    wack = 1'b0;
    tick();

    // drop cycle with two outstanding, then a late ack
    sstb = 1'b1; saddr = 26'd4;
    tick();
    saddr = 26'd5;
    tick();
    sstb = 1'b0; scyc = 1'b0;
    tick();
    check("drop_wcyc", b_wcyc, 0);
    check("drop_wstb", b_wstb, 0);
    wack = 1'b1; wdata_in = 64'h55555555_66666666;
    tick();
    check("drop_no_sack", b_sack, 0);
    wack = 1'b0;
    scyc = 1'b1; sstb = 1'b1; saddr = 26'd5;
    tick();
    sstb = 1'b0;
    wack = 1'b1; wdata_in = 64'hFEDCBA98_76543210;
    tick();
    check("drop_new_sack", b_sack, 1);
    check("drop_new_be", b_sdata, 32'h76543210);
    check("drop_new_le", l_sdata, 32'hFEDCBA98);
    wack = 1'b0;
    tick();

    // reset in the middle of a burst
    sstb = 1'b1; swe = 1'b1; saddr = 26'd4; sdata = 32'hCAFEF00D;
    tick();
    sstb = 1'b0; swe = 1'b0; rst = 1'b1; wack = 1'b1;
    tick();
    check("mrst_wcyc", b_wcyc, 0);
    check("mrst_wstb", b_wstb, 0);
    check("mrst_wdata", b_wdata, 0);
    check("mrst_wsel", b_wsel, 0);
    check("mrst_waddr", b_waddr, 0);
    check("mrst_sack", b_sack, 0);
    check("mrst_sdata", b_sdata, 0);
    rst = 1'b0; wack = 1'b0;
    sstb = 1'b1; saddr = 26'd7;
    tick();
    sstb = 1'b0;
    wack = 1'b1; wdata_in = 64'h01234567_89ABCDEF;
    tick();
    check("mrst_rd_sack", b_sack, 1);
    check("mrst_rd_be", b_sdata, 32'h89ABCDEF);
    check("mrst_rd_le", l_sdata, 32'h01234567);
    wack = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
